user_module_phase_step_decoder: RTL and testbench

- Receive-side counterpart of the 2-bit Johnson phase generator, which drives four active-low, one-hot phase lines.
- Samples those four lines and synchronises them, then filters out glitches.
- Recovers step direction and keeps a wrapping 4-bit position count.
- Flags illegal two-phase jumps. Packaged as a standard 8-in/8-out user module.

---
 rtl/user_module_phase_step_decoder.sv | 134 +++++++++++++
 tb/tb_user_module_phase_step_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/user_module_phase_step_decoder.sv
// Receive-side decoder for four active-low one-hot phase lines: synchronise, glitch-filter,
// recover step direction, keep a wrapping 4-bit position and flag illegal two-phase jumps.
module user_module_phase_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst_n;
  logic [3:0] ph_n;
  logic       clr_cnt;
  logic       clr_err;

  assign clk     = io_in[0];
  assign rst_n   = io_in[1];
  assign ph_n    = io_in[5:2];
  assign clr_cnt = io_in[6];
  assign clr_err = io_in[7];

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1111;
    end else begin
      sync_q[0] <= ph_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A code counts as stable once the previous FILTER-1 synchronised samples all agree with it.
  logic stable;

  generate
    if (FILTER > 1) begin : g_hist
      logic [3:0] hist_q [FILTER-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < FILTER - 1; i++) hist_q[i] <= 4'b1111;
        end else begin
          hist_q[0] <= s;
          for (int i = 1; i < FILTER - 1; i++) hist_q[i] <= hist_q[i-1];
        end
      end

      always_comb begin
        stable = 1'b1;
        for (int i = 0; i < FILTER - 1; i++) begin
          if (hist_q[i] != s) stable = 1'b0;
        end
      end
    end else begin : g_nohist
      assign stable = 1'b1;
    end
  endgenerate

  logic       valid;
  logic [1:0] n;

  always_comb begin
    valid = 1'b0;
    n     = 2'd0;
    case (s)
      4'b1110: begin valid = 1'b1; n = 2'd0; end
      4'b1101: begin valid = 1'b1; n = 2'd1; end
      4'b1011: begin valid = 1'b1; n = 2'd2; end
      4'b0111: begin valid = 1'b1; n = 2'd3; end
      default: begin valid = 1'b0; n = 2'd0; end
    endcase
  end

  logic [3:0] pos_q;
  logic       dir_q;
  logic       step_q;
  logic       err_q;
  logic       lock_q;
  logic [1:0] a_q;

  logic       accept;
  logic [1:0] diff;
  logic       fwd;
  logic       bwd;
  logic       jump;

  // Modulo-4 distance from the last accepted phase decides forward, backward or illegal jump.
  assign accept = valid & stable;
  assign diff   = n - a_q;
  assign fwd    = accept & lock_q & (diff == 2'd1);
  assign bwd    = accept & lock_q & (diff == 2'd3);
  assign jump   = accept & lock_q & (diff == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q  <= 4'd0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      lock_q <= 1'b0;
      a_q    <= 2'd0;
    end else begin
      step_q <= fwd | bwd;

      if (accept) begin
        if (!lock_q) begin
          a_q    <= n;
          lock_q <= 1'b1;
        end else if (diff != 2'd0) begin
          a_q <= n;
        end
      end

      if (clr_cnt)  pos_q <= 4'd0;
      else if (fwd) pos_q <= pos_q + 4'd1;
      else if (bwd) pos_q <= pos_q - 4'd1;

      if (fwd)      dir_q <= 1'b1;
      else if (bwd) dir_q <= 1'b0;

      // A jump on the same edge as clr_err must still leave the error set.
      if (jump)         err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
    end
  end

  assign io_out = {lock_q, err_q, step_q, dir_q, pos_q};

endmodule

// File: tb/tb_user_module_phase_step_decoder.sv
// Directed bench for the phase step decoder: a reference model pushes expected outputs
// into a queue per edge, and each is popped and compared one time unit after that edge.
module tb_user_module_phase_step_decoder;

  localparam int S  = 2;
  localparam int F  = 2;
  localparam int NS = S + F - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] ph_n = 4'hF;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {clr_err, clr_cnt, ph_n, rst_n, clk};

  user_module_phase_step_decoder #(.SYNC_STAGES(S), .FILTER(F)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  logic [3:0] m_pos;
  logic       m_dir;
  logic       m_step;
  logic       m_err;
  logic       m_lock;
  logic [1:0] m_a;
  logic [3:0] samp [NS];

  logic [7:0] exp_q [$];
  int vectors     = 0;
  int miscompares = 0;
  int step_seen   = 0;

  // samp[k] holds the input sampled k+1 edges ago; the synchroniser output is samp[S-1].
  task automatic model_edge(input logic [3:0] ph, input logic rn, input logic cc,
                            input logic ce, output logic [7:0] want);
    logic [3:0] s;
    logic       ok;
    logic [1:0] n;
    logic [1:0] d;
    logic       f;
    logic       b;
    logic       jmp;
    if (!rn) begin
      m_pos  = 4'd0;
      m_dir  = 1'b0;
      m_step = 1'b0;
      m_err  = 1'b0;
      m_lock = 1'b0;
      m_a    = 2'd0;
      for (int k = 0; k < NS; k++) samp[k] = 4'hF;
    end else begin
      s  = samp[S-1];
      ok = ($countones(~s) == 1);
      for (int k = 1; k < F; k++) if (samp[S-1+k] != s) ok = 1'b0;
      n = 2'd0;
      for (int i = 0; i < 4; i++) if (!s[i]) n = i[1:0];
      f = 1'b0; b = 1'b0; jmp = 1'b0;
      m_step = 1'b0;
      if (ok) begin
        if (!m_lock) begin
          m_a    = n;
          m_lock = 1'b1;
        end else begin
          d   = n - m_a;
          f   = (d == 2'd1);
          b   = (d == 2'd3);
          jmp = (d == 2'd2);
          if (d != 2'd0) m_a = n;
        end
      end
      if (f) begin m_pos = m_pos + 4'd1; m_dir = 1'b1; m_step = 1'b1; end
      if (b) begin m_pos = m_pos - 4'd1; m_dir = 1'b0; m_step = 1'b1; end
      if (cc) m_pos = 4'd0;
      if (jmp) m_err = 1'b1;
      else if (ce) m_err = 1'b0;
      for (int k = NS - 1; k > 0; k--) samp[k] = samp[k-1];
      samp[0] = ph;
    end
    want = {m_lock, m_err, m_step, m_dir, m_pos};
  endtask

  task automatic applyStimulus(input logic [3:0] ph, input logic rn, input logic cc,
                               input logic ce, input int cycles);
    logic [7:0] want;
    logic [7:0] got;
    for (int c = 0; c < cycles; c++) begin
      ph_n    = ph;
      rst_n   = rn;
      clr_cnt = cc;
      clr_err = ce;
      model_edge(ph, rn, cc, ce, want);
      exp_q.push_back(want);
      @(posedge clk);
      #1;
      got  = io_out;
      want = exp_q.pop_front();
      vectors++;
      assert (got === want)
      else begin
        miscompares++;
        $error("[TB] FAIL cycle ph_n=%b observed=%h expected=%h", ph, got, want);
      end
      if (got[5] === 1'b1) step_seen++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] want);
    vectors++;
    assert (io_out === want)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, io_out, want);
    end
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  initial begin
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 10);
    checkOutput("idle", 8'h00);

    step_seen = 0;
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("lock_phase0", 8'h80);
    check_count("lock_no_step", step_seen, 0);

    // Full forward revolution 1,2,3,0.
    step_seen = 0;
    applyStimulus(4'hD, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'h7, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("fwd_pos4", 8'h94);
    check_count("fwd_steps", step_seen, 4);

    // Backward wrap 0 -> 15 -> 14.
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("relock", 8'h80);
    step_seen = 0;
    applyStimulus(4'h7, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("bwd_wrap15", 8'h8F);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("bwd_pos14", 8'h8E);
    check_count("bwd_steps", step_seen, 2);

    // Single-cycle glitch and a multi-low code are both ignored.
    step_seen = 0;
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus(4'hD, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 4);
    checkOutput("glitch", 8'h8E);
    applyStimulus(4'hC, 1'b1, 1'b0, 1'b0, 5);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("multi_low", 8'h8E);
    check_count("glitch_steps", step_seen, 0);

    // Illegal jump 2 -> 0, clear, then jump 0 -> 2 with clr_err on the detect edge.
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("jump_err", 8'hCE);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b1, 1);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 2);
    checkOutput("err_cleared", 8'h8E);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b1, 1);
    checkOutput("set_wins", 8'hCE);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 2);
    checkOutput("err_sticky", 8'hCE);

    // Count clear on a forward step edge, then reset in the middle of filtering.
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'hD, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'h7, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(4'hD, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("pos5", 8'h95);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus(4'hB, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("clr_on_step", 8'hB0);
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("step_drops", 8'h90);
    applyStimulus(4'h7, 1'b1, 1'b0, 1'b0, 2);
    applyStimulus(4'h7, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("mid_reset", 8'h00);
    step_seen = 0;
    applyStimulus(4'h7, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("relock_only", 8'h80);
    check_count("relock_steps", step_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
